// File: rtl/mux_pkg.sv
// Shared types and widths for the mux/demux library blocks.
package mux_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic {
    COLLECT,
    HOLD
  } state_e;

endpackage

// File: rtl/demux_collect8_if.sv
// Bit-in / byte-out handshake bundle for demux_collect8.
interface demux_collect8_if;

  logic                        in_valid;
  logic                        in_ready;
  logic                        in_bit;
  logic [mux_pkg::SEL_W-1:0]   in_sel;
  logic                        mode;
  logic [mux_pkg::BYTE_W-1:0]  out;
  logic                        out_valid;
  logic                        out_ready;
  logic [mux_pkg::BYTE_W-1:0]  fill;

  modport master (
    output in_valid, in_bit, in_sel, mode, out_ready,
    input  in_ready, out, out_valid, fill
  );

  modport slave (
    input  in_valid, in_bit, in_sel, mode, out_ready,
    output in_ready, out, out_valid, fill
  );

endinterface

// File: rtl/demux1_8.sv
// Gate-level 1:8 decoder: y = onehot(sel) when en, else all zero.
module demux1_8 #(
  parameter real DELAY = 0.05
) (
  input  wire       en,
  input  wire [2:0] sel,
  output wire [7:0] y
);

  wire [2:0] sel_n;

  not #(DELAY) u_not[2:0] (sel_n, sel);

  for (genvar i = 0; i < 8; i++) begin : g_dec
    localparam logic [2:0] Code = 3'(i);
    and #(DELAY) u_and (y[i], en,
                        Code[2] ? sel[2] : sel_n[2],
                        Code[1] ? sel[1] : sel_n[1],
                        Code[0] ? sel[0] : sel_n[0]);
  end

endmodule

// File: rtl/demux_collect8.sv
// Steers accepted serial bits into byte positions and holds the finished byte
// behind a valid/ready handshake.
module demux_collect8
  import mux_pkg::*;
#(
  parameter real DELAY = 0.05
) (
  input  logic             clk,
  input  logic             reset,
  demux_collect8_if.slave  bus
);

  state_e              state_q;
  logic [BYTE_W-1:0]   data_q;
  logic [BYTE_W-1:0]   fill_q;
  logic [SEL_W-1:0]    cnt_q;

  logic                accept;
  logic [SEL_W-1:0]    idx;
  logic [BYTE_W-1:0]   we;
  logic [BYTE_W-1:0]   fill_nxt;
  logic                complete;

  assign accept   = bus.in_valid & (state_q == COLLECT);
  assign idx      = bus.mode ? cnt_q : bus.in_sel;

  demux1_8 #(
    .DELAY (DELAY)
  ) u_dec (
    .en  (accept),
    .sel (idx),
    .y   (we)
  );

  // Overwrites of a filled position leave the mask unchanged, so only
  // distinct positions bring the byte closer to completion.
  assign fill_nxt = fill_q | we;
  assign complete = &fill_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      data_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            data_q <= (data_q & ~we) | ({BYTE_W{bus.in_bit}} & we);
            fill_q <= fill_nxt;
            if (bus.mode) cnt_q <= cnt_q + 3'd1;
            if (complete) begin
              state_q <= HOLD;
              cnt_q   <= '0;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q <= COLLECT;
            fill_q  <= '0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out       = data_q;
  assign bus.fill      = fill_q;

endmodule
